// File: rtl/ex_stage_pkg.sv
// Shared constants and bundles for the 16-bit execute stage.
// Optional iterative multiplier is enabled with EX_MUL_EN.
package ex_stage_pkg;

  localparam int DW = 16;
  localparam int RW = 3;
  localparam int IW = 16;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;
  localparam logic [3:0] FN_XOR = 4'd4;
  localparam logic [3:0] FN_SLL = 4'd5;
  localparam logic [3:0] FN_SRL = 4'd6;
  localparam logic [3:0] FN_SRA = 4'd7;
  localparam logic [3:0] FN_SLT = 4'd8;
  localparam logic [3:0] FN_MUL = 4'd9;

  localparam int MUL_STEPS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] result;
    logic [DW-1:0] store_data;
    logic [RW-1:0] reg3;
    logic          result_or_mem;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
  } ex_mem_t;

  function automatic logic [DW-1:0] sext6(
    input logic [5:0] v
  );
    return {{(DW-6){v[5]}}, v};
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative 16-step shift-add multiplier, low 16 bits of product.
// Instantiated by ex_stage only when EX_MUL_EN is defined.
module ex_mul_iter
  import ex_stage_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] product_o
);

  // The start edge already performs step 0, so BUSY
  // performs the remaining 15 and leaves on the last.
  localparam logic [3:0] LAST = 4'(MUL_STEPS - 2);

  mul_state_e    state_q;
  logic [DW-1:0] mcand_q;
  logic [DW-1:0] mplier_q;
  logic [DW-1:0] acc_q;
  logic [3:0]    cnt_q;
  logic          busy_q;
  logic          done_q;

  // Control FSM plus shift-add datapath, one step per edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            acc_q    <= b_i[0] ? a_i : '0;
            mcand_q  <= a_i << 1;
            mplier_q <= b_i >> 1;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc_q    <= acc_q
                    + (mplier_q[0] ? mcand_q : '0);
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 4'd1;
          if (cnt_q == LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump resolve, EX/MEM register.
// EX_MUL_EN adds the iterative multiplier and its stall.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] ex_PC_i,
  input  logic [DW-1:0] ex_data1_i,
  input  logic [DW-1:0] ex_data2_i,
  input  logic [IW-1:0] ex_inst_i,
  input  logic [RW-1:0] ex_reg3_i,
  input  logic          ex_jump_i,
  input  logic          ex_immOrReg_i,
  input  logic          ex_branch_i,
  input  logic          ex_resultOrMem_i,
  input  logic          ex_memRead_i,
  input  logic          ex_memWrite_i,
  input  logic          ex_regWrite_i,
  output logic          stall_o,
  output logic          pc_redirect_o,
  output logic [DW-1:0] pc_target_o,
  output logic [DW-1:0] mem_PC_o,
  output logic [DW-1:0] mem_result_o,
  output logic [DW-1:0] mem_storeData_o,
  output logic [RW-1:0] mem_reg3_o,
  output logic          mem_resultOrMem_o,
  output logic          mem_memRead_o,
  output logic          mem_memWrite_o,
  output logic          mem_regWrite_o
);

  logic [3:0]    opcode;
  logic [3:0]    funct;
  logic [DW-1:0] imm;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [3:0]    shamt;
  logic [DW-1:0] alu_res;
  logic          fn_valid;
  logic          stall;
  logic          taken;
  ex_mem_t       ex_mem_d;
  ex_mem_t       ex_mem_q;

  assign opcode = ex_inst_i[15:12];
  assign funct  = ex_inst_i[3:0];
  assign imm    = sext6(ex_inst_i[5:0]);
  assign op_a   = ex_data1_i;
  assign op_b   = ex_immOrReg_i ? imm : ex_data2_i;
  assign shamt  = op_b[3:0];

`ifdef EX_MUL_EN
  logic          is_mul;
  logic          mul_start;
  logic          mul_busy;
  logic          mul_done;
  logic [DW-1:0] mul_product;

  assign is_mul = (opcode == OP_ALU)
               && (funct == FN_MUL);

  // Start only from IDLE; DONE must not restart
  // while upstream still holds the same MUL.
  assign mul_start = is_mul & ~mul_busy & ~mul_done;

  ex_mul_iter u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .a_i       (op_a),
    .b_i       (op_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign stall = rst_i & (mul_start | mul_busy);
`else
  assign stall = 1'b0;
`endif

  // ALU result and legality of the funct field.
  always_comb begin
    alu_res  = op_a + op_b;
    fn_valid = 1'b1;
    if (opcode == OP_ALU) begin
      unique case (funct)
        FN_ADD: alu_res = op_a + op_b;
        FN_SUB: alu_res = op_a - op_b;
        FN_AND: alu_res = op_a & op_b;
        FN_OR:  alu_res = op_a | op_b;
        FN_XOR: alu_res = op_a ^ op_b;
        FN_SLL: alu_res = op_a << shamt;
        FN_SRL: alu_res = op_a >> shamt;
        FN_SRA: alu_res = DW'($signed(op_a) >>> shamt);
        FN_SLT: alu_res = {{(DW-1){1'b0}},
                           $signed(op_a) < $signed(op_b)};
`ifdef EX_MUL_EN
        FN_MUL: alu_res = mul_product;
`endif
        default: begin
          alu_res  = '0;
          fn_valid = 1'b0;
        end
      endcase
    end
  end

  assign taken = ex_branch_i
              & (ex_data1_i == ex_data2_i);

  assign pc_redirect_o = rst_i & ~stall
                       & (ex_jump_i | taken);

  assign pc_target_o = ex_jump_i
    ? {ex_PC_i[15:12], ex_inst_i[11:0]}
    : ex_PC_i + 16'd1 + imm;

  assign stall_o = stall;

  // Next EX/MEM contents; stalls and bad functs become bubbles.
  always_comb begin
    ex_mem_d = '0;
    if (!stall && fn_valid) begin
      ex_mem_d.pc            = ex_PC_i;
      ex_mem_d.result        = alu_res;
      ex_mem_d.store_data    = ex_data2_i;
      ex_mem_d.reg3          = ex_reg3_i;
      ex_mem_d.result_or_mem = ex_resultOrMem_i;
      ex_mem_d.mem_read      = ex_memRead_i;
      ex_mem_d.mem_write     = ex_memWrite_i;
      ex_mem_d.reg_write     = ex_regWrite_i;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign mem_PC_o          = ex_mem_q.pc;
  assign mem_result_o      = ex_mem_q.result;
  assign mem_storeData_o   = ex_mem_q.store_data;
  assign mem_reg3_o        = ex_mem_q.reg3;
  assign mem_resultOrMem_o = ex_mem_q.result_or_mem;
  assign mem_memRead_o     = ex_mem_q.mem_read;
  assign mem_memWrite_o    = ex_mem_q.mem_write;
  assign mem_regWrite_o    = ex_mem_q.reg_write;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage against a behavioural model.
// MUL scenarios are exercised only when EX_MUL_EN is defined.
`timescale 1ns/1ps
module tb_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] ex_PC_i, ex_data1_i, ex_data2_i, ex_inst_i;
  logic [2:0]  ex_reg3_i;
  logic        ex_jump_i, ex_immOrReg_i, ex_branch_i;
  logic        ex_resultOrMem_i, ex_memRead_i;
  logic        ex_memWrite_i, ex_regWrite_i;
  logic        stall_o, pc_redirect_o;
  logic [15:0] pc_target_o;
  logic [15:0] mem_PC_o, mem_result_o, mem_storeData_o;
  logic [2:0]  mem_reg3_o;
  logic        mem_resultOrMem_o, mem_memRead_o;
  logic        mem_memWrite_o, mem_regWrite_o;

  always #5 clk_i = ~clk_i;

  ex_stage dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .ex_PC_i           (ex_PC_i),
    .ex_data1_i        (ex_data1_i),
    .ex_data2_i        (ex_data2_i),
    .ex_inst_i         (ex_inst_i),
    .ex_reg3_i         (ex_reg3_i),
    .ex_jump_i         (ex_jump_i),
    .ex_immOrReg_i     (ex_immOrReg_i),
    .ex_branch_i       (ex_branch_i),
    .ex_resultOrMem_i  (ex_resultOrMem_i),
    .ex_memRead_i      (ex_memRead_i),
    .ex_memWrite_i     (ex_memWrite_i),
    .ex_regWrite_i     (ex_regWrite_i),
    .stall_o           (stall_o),
    .pc_redirect_o     (pc_redirect_o),
    .pc_target_o       (pc_target_o),
    .mem_PC_o          (mem_PC_o),
    .mem_result_o      (mem_result_o),
    .mem_storeData_o   (mem_storeData_o),
    .mem_reg3_o        (mem_reg3_o),
    .mem_resultOrMem_o (mem_resultOrMem_o),
    .mem_memRead_o     (mem_memRead_o),
    .mem_memWrite_o    (mem_memWrite_o),
    .mem_regWrite_o    (mem_regWrite_o)
  );

`ifdef EX_MUL_EN
  localparam int MAXF = 9;
`else
  localparam int MAXF = 8;
`endif

  typedef struct {
    logic [15:0] pc, inst, d1, d2;
    logic [2:0]  r3;
    logic jmp, imm, br, rom, mr, mw, rw;
  } op_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic op_t nop();
    op_t o;
    o = '{default: '0};
    return o;
  endfunction

  function automatic int sx6(input logic [15:0] inst);
    int v;
    v = int'(inst[5:0]);
    if (v >= 32) v -= 64;
    return v;
  endfunction

  function automatic int sgn(input logic [15:0] x);
    int v;
    v = int'(x);
    if (v >= 32768) v -= 65536;
    return v;
  endfunction

  function automatic logic [15:0] ref_alu(input op_t o);
    int a, b, s, sa, sb;
    longint p;
    a  = int'(o.d1);
    b  = o.imm ? (sx6(o.inst) & 16'hFFFF) : int'(o.d2);
    s  = b % 16;
    sa = sgn(16'(a));
    sb = sgn(16'(b));
    if (o.inst[15:12] != 4'h0) return 16'(a + b);
    case (int'(o.inst[3:0]))
      0: return 16'(a + b);
      1: return 16'(a - b);
      2: return 16'(a & b);
      3: return 16'(a | b);
      4: return 16'(a ^ b);
      5: return 16'(a * (1 << s));
      6: return 16'(a / (1 << s));
      7: return 16'(sa >>> s);
      8: return (sa < sb) ? 16'd1 : 16'd0;
      9: begin
        p = longint'(a) * longint'(b);
        return 16'(p);
      end
      default: return 16'd0;
    endcase
  endfunction

  function automatic bit ref_bubble(input op_t o);
    return (o.inst[15:12] == 4'h0)
        && (int'(o.inst[3:0]) > MAXF);
  endfunction

  task automatic drive(input op_t o);
    ex_PC_i          = o.pc;
    ex_inst_i        = o.inst;
    ex_data1_i       = o.d1;
    ex_data2_i       = o.d2;
    ex_reg3_i        = o.r3;
    ex_jump_i        = o.jmp;
    ex_immOrReg_i    = o.imm;
    ex_branch_i      = o.br;
    ex_resultOrMem_i = o.rom;
    ex_memRead_i     = o.mr;
    ex_memWrite_i    = o.mw;
    ex_regWrite_i    = o.rw;
  endtask

  function automatic logic [3:0] ctl_out();
    return {mem_resultOrMem_o, mem_memRead_o,
            mem_memWrite_o, mem_regWrite_o};
  endfunction

  // Single-cycle instruction; called right after a negedge.
  task automatic exec_one(input op_t o, input string tag);
    bit red;
    logic [15:0] tgt;
    drive(o);
    #1;
    red = o.jmp || (o.br && (o.d1 == o.d2));
    check({tag, ".stall"}, 32'(stall_o), 32'd0);
    check({tag, ".redir"}, 32'(pc_redirect_o), 32'(red));
    if (red) begin
      if (o.jmp) tgt = {o.pc[15:12], o.inst[11:0]};
      else       tgt = 16'(int'(o.pc) + 1 + sx6(o.inst));
      check({tag, ".tgt"}, 32'(pc_target_o), 32'(tgt));
    end
    @(posedge clk_i);
    #1;
    if (ref_bubble(o)) begin
      check({tag, ".bub"}, 32'(ctl_out()), 32'd0);
    end else begin
      check({tag, ".res"}, 32'(mem_result_o),
            32'(ref_alu(o)));
      check({tag, ".st"}, 32'(mem_storeData_o), 32'(o.d2));
      check({tag, ".pc"}, 32'(mem_PC_o), 32'(o.pc));
      check({tag, ".r3"}, 32'(mem_reg3_o), 32'(o.r3));
      check({tag, ".ctl"}, 32'(ctl_out()),
            32'({o.rom, o.mr, o.mw, o.rw}));
    end
    @(negedge clk_i);
  endtask

  function automatic op_t mk_mul(input logic [15:0] a,
                                 input logic [15:0] b,
                                 input logic br);
    op_t o;
    o      = nop();
    o.inst = 16'h0009;
    o.d1   = a;
    o.d2   = b;
    o.r3   = 3'd5;
    o.rw   = 1'b1;
    o.br   = br;
    o.pc   = 16'h0200;
    return o;
  endfunction

  // Multi-cycle MUL: 16 stalled cycles, then product.
  task automatic exec_mul(input logic [15:0] a,
                          input logic [15:0] b,
                          input logic br,
                          input string tag);
    op_t o;
    int hi, bub, red;
    longint p;
    o   = mk_mul(a, b, br);
    hi  = 0;
    bub = 0;
    red = 0;
    p   = longint'(a) * longint'(b);
    drive(o);
    for (int i = 0; i < 16; i++) begin
      #1;
      if (stall_o === 1'b1) hi++;
      if (pc_redirect_o !== 1'b0) red++;
      @(posedge clk_i);
      #1;
      if (ctl_out() !== 4'd0) bub++;
      @(negedge clk_i);
    end
    #1;
    check({tag, ".stall_end"}, 32'(stall_o), 32'd0);
    check({tag, ".redir_end"}, 32'(pc_redirect_o),
          32'(br && (a == b)));
    @(posedge clk_i);
    #1;
    check({tag, ".prod"}, 32'(mem_result_o), 32'(16'(p)));
    check({tag, ".rw"}, 32'(mem_regWrite_o), 32'd1);
    check({tag, ".r3"}, 32'(mem_reg3_o), 32'd5);
    check({tag, ".hi"}, 32'(hi), 32'd16);
    check({tag, ".bub"}, 32'(bub), 32'd0);
    check({tag, ".redq"}, 32'(red), 32'd0);
    @(negedge clk_i);
  endtask

  initial begin
    op_t o;
    rst_i = 1'b0;
    o = mk_mul(16'h0003, 16'h0004, 1'b0);
    drive(o);
    repeat (2) @(negedge clk_i);
    check("rst.stall", 32'(stall_o), 32'd0);
    check("rst.redir", 32'(pc_redirect_o), 32'd0);
    check("rst.res", 32'(mem_result_o), 32'd0);
    check("rst.ctl", 32'(ctl_out()), 32'd0);
    check("rst.pc", 32'(mem_PC_o), 32'd0);
    rst_i = 1'b1;

    o = nop(); o.d1 = 16'h7FFF; o.d2 = 16'h0001;
    o.rw = 1'b1; o.r3 = 3'd2; o.pc = 16'h0010;
    exec_one(o, "add");

    o = nop(); o.inst = 16'h0007;
    o.d1 = 16'h8000; o.d2 = 16'h0003; o.rw = 1'b1;
    exec_one(o, "sra");

    o = nop(); o.inst = 16'h0008;
    o.d1 = 16'hFFFF; o.d2 = 16'h0001; o.rw = 1'b1;
    exec_one(o, "slt");

    o = nop(); o.inst = 16'h403E; o.pc = 16'h0040;
    o.d1 = 16'd5; o.d2 = 16'd5; o.br = 1'b1; o.imm = 1'b1;
    exec_one(o, "beq_t");

    o.d2 = 16'd6;
    exec_one(o, "beq_nt");

    o = nop(); o.inst = 16'h5456; o.pc = 16'hA123;
    o.jmp = 1'b1;
    exec_one(o, "jmp");

    o = nop(); o.inst = 16'h000C; o.rw = 1'b1;
    o.mw = 1'b1; o.d1 = 16'h1111;
    exec_one(o, "undef");

    for (int i = 0; i < 150; i++) begin
      o = nop();
      o.inst = 16'($urandom);
      if ($urandom_range(0, 2) != 0) o.inst[15:12] = 4'h0;
      if (o.inst[15:12] == 4'h0 && o.inst[3:0] == 4'd9)
        o.inst[3:0] = (MAXF == 9) ? 4'd0 : 4'd9;
      o.pc  = 16'($urandom);
      o.d1  = 16'($urandom);
      o.d2  = $urandom_range(0, 1) ? o.d1 : 16'($urandom);
      o.r3  = 3'($urandom);
      o.jmp = ($urandom_range(0, 3) == 0);
      o.imm = 1'($urandom);
      o.br  = 1'($urandom);
      o.rom = 1'($urandom);
      o.mr  = 1'($urandom);
      o.mw  = 1'($urandom);
      o.rw  = 1'($urandom);
      exec_one(o, $sformatf("rnd%0d", i));
    end

`ifdef EX_MUL_EN
    exec_mul(16'h0123, 16'h0010, 1'b0, "mul1");
    exec_mul(16'hFFFF, 16'hFFFF, 1'b0, "mul2");
    exec_mul(16'd5, 16'd5, 1'b1, "mulbr");
    for (int i = 0; i < 4; i++)
      exec_mul(16'($urandom), 16'($urandom), 1'b0,
               $sformatf("mulr%0d", i));

    o = mk_mul(16'h0BAD, 16'h0077, 1'b0);
    drive(o);
    repeat (8) @(negedge clk_i);
    #1;
    check("rmid.stall_pre", 32'(stall_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check("rmid.stall", 32'(stall_o), 32'd0);
    check("rmid.redir", 32'(pc_redirect_o), 32'd0);
    check("rmid.ctl", 32'(ctl_out()), 32'd0);
    check("rmid.res", 32'(mem_result_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    exec_mul(16'h0321, 16'h0042, 1'b0, "mulpost");
`else
    o = mk_mul(16'h0123, 16'h0010, 1'b0);
    exec_one(o, "mul_off");
`endif

    o = nop(); o.d1 = 16'h1234; o.d2 = 16'h1111;
    o.rw = 1'b1; o.mr = 1'b1; o.pc = 16'h0077;
    exec_one(o, "pre_rst");
    #1;
    rst_i = 1'b0;
    #1;
    check("arst.res", 32'(mem_result_o), 32'd0);
    check("arst.ctl", 32'(ctl_out()), 32'd0);
    check("arst.pc", 32'(mem_PC_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    o.d1 = 16'h0F0F;
    exec_one(o, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
